// File: rtl/lsu_align_unit.sv
// lsu_align_unit: load/store alignment engine between the MEM stage and the
// data-memory port. Builds byte enables and lane-shifted store data, splits
// accesses that cross a bus word into two aligned beats, and extracts and
// sign/zero-extends load data. Illegal accesses complete as faults without
// touching memory.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*_i / req_ready_o   pipeline request (accepted in IDLE only)
//   rsp_*_o                 one-cycle completion pulse with data / fault
//   mem_req_*               memory beat request (held until mem_req_ready_i)
//   mem_rsp_valid_i, mem_rdata_i  read data or write acknowledge per beat
//
// state | meaning
// IDLE  | ready for a request; latch and decode on req_valid_i
// REQ0  | first (or only) beat presented to memory
// RSP0  | waiting for first beat data / ack
// REQ1  | second beat of a word-crossing access presented
// RSP1  | waiting for second beat data / ack
// DONE  | rsp_valid_o pulse, then back to IDLE
module lsu_align_unit #(
  parameter int XLEN           = 32,
  parameter int ALEN           = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ALEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_fault_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [ALEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ALEN-1:0]   base_q, base_d;
  logic [OW-1:0]     off_q, off_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              cross_q, cross_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic [XLEN-1:0]   beat1_q, beat1_d;

  // request decode
  logic [3:0]        req_size;
  logic [OW-1:0]     req_off;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_fault;

  // lane datapath from latched fields
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [XLEN-1:0]   rd_low;
  logic [XLEN-1:0]   lane_mask;
  logic              rd_sign;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    req_size  = 4'd1 << req_funct3_i[1:0];
    req_off   = req_addr_i[OW-1:0];
    req_end   = 5'(req_off) + 5'(req_size);
    req_cross = req_end > 5'(NB);
    req_fault = (req_funct3_i == 3'b111)
             || ((XLEN == 32) && (req_funct3_i[1:0] == 2'd3))
             || ((XLEN == 32) && (req_funct3_i == 3'b110))
             || (req_we_i && req_funct3_i[2])
             || (req_cross && (MISALIGN_SPLIT == 0));
  end

  // Shifting into a double-width window gives beat 0 in the low half and the
  // spill-over for beat 1 in the high half, for both enables and data.
  always_comb begin
    be_wide = '0;
    case (funct3_q[1:0])
      2'd0:    be_wide[0:0] = '1;
      2'd1:    be_wide[1:0] = '1;
      2'd2:    be_wide[3:0] = '1;
      default: be_wide[7:0] = '1;
    endcase
    be_wide    = be_wide << off_q;
    wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
  end

  always_comb begin
    rd_low    = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});
    lane_mask = '0;
    case (funct3_q[1:0])
      2'd0:    begin lane_mask[7:0]  = '1; rd_sign = rd_low[7];  end
      2'd1:    begin lane_mask[15:0] = '1; rd_sign = rd_low[15]; end
      2'd2:    begin lane_mask[31:0] = '1; rd_sign = rd_low[31]; end
      default: begin lane_mask       = '1; rd_sign = rd_low[XLEN-1]; end
    endcase
    load_ext = (rd_low & lane_mask) | ((rd_sign && !funct3_q[2]) ? ~lane_mask : '0);
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    funct3_d        = funct3_q;
    base_d          = base_q;
    off_d           = off_q;
    wdata_d         = wdata_q;
    cross_d         = cross_q;
    fault_d         = fault_q;
    beat0_d         = beat0_q;
    beat1_d         = beat1_q;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    rsp_fault_o     = 1'b0;
    rsp_rdata_o     = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_be_o        = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          base_d   = req_addr_i & ~ALEN'(NB - 1);
          off_d    = req_off;
          wdata_d  = req_wdata_i;
          cross_d  = req_cross;
          fault_d  = req_fault;
          beat0_d  = '0;
          beat1_d  = '0;
          state_d  = req_fault ? S_DONE : S_REQ0;
        end
      end
      S_REQ0: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = we_q;
        mem_addr_o      = base_q;
        mem_be_o        = be_wide[NB-1:0];
        mem_wdata_o     = wdata_wide[XLEN-1:0];
        if (mem_req_ready_i) state_d = S_RSP0;
      end
      S_RSP0: begin
        if (mem_rsp_valid_i) begin
          beat0_d = mem_rdata_i;
          state_d = cross_q ? S_REQ1 : S_DONE;
        end
      end
      S_REQ1: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = we_q;
        mem_addr_o      = base_q + ALEN'(NB);
        mem_be_o        = be_wide[2*NB-1:NB];
        mem_wdata_o     = wdata_wide[2*XLEN-1:XLEN];
        if (mem_req_ready_i) state_d = S_RSP1;
      end
      S_RSP1: begin
        if (mem_rsp_valid_i) begin
          beat1_d = mem_rdata_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_o = 1'b1;
        rsp_fault_o = fault_q;
        rsp_rdata_o = (fault_q || we_q) ? '0 : load_ext;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      base_q   <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      cross_q  <= 1'b0;
      fault_q  <= 1'b0;
      beat0_q  <= '0;
      beat1_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      base_q   <= base_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      cross_q  <= cross_d;
      fault_q  <= fault_d;
      beat0_q  <= beat0_d;
      beat1_q  <= beat1_d;
    end
  end

endmodule
